wb_serial_bridge: RTL
=====================

# wb_serial_bridge

Pipelined Wishbone slave that tunnels each accepted bus cycle out as a byte-serial request frame on an AXI-Stream output and completes the cycle when the byte-serial response returns on an AXI-Stream input. It is the far-end counterpart of `serial_wb_master`: placed in front of `uart_tx`/`uart_rx`, it lets an on-chip Wishbone master drive a remote `serial_wb_master` over a UART link. One transaction is outstanding at a time.

## Interface
- `ADDR_BITS`, 8, Wishbone address width, 1..32; `ADDR_BYTES = ceil(ADDR_BITS/8)`.
- `BYTES`, 1, Wishbone data width in bytes, 1..4; the select width equals `BYTES`.

- `clk`: in, 1. Single clock domain.
- `sresetn`: in, 1. Reset, asynchronous, active-low.
- `s_wb_cyc`, `s_wb_stb`, `s_wb_we`: in, 1 each. Wishbone request.
- `s_wb_addr`: in, ADDR_BITS. Request address.
- `s_wb_sel`: in, BYTES. Byte selects.
- `s_wb_dat_m2s`: in, 8*BYTES. Write data.
- `s_wb_dat_s2m`: out, 8*BYTES. Read data.
- `s_wb_ack`: out, 1. One-cycle completion pulse.
- `s_wb_stall`: out, 1. High while busy.
- `axis_o_tready`: in, 1. Request stream handshake.
- `axis_o_tvalid`, `axis_o_tlast`: out, 1 each. Request stream handshake and frame end.
- `axis_o_tdata`: out, 8. Request stream byte.
- `axis_i_tvalid`, `axis_i_tlast`: in, 1 each. Response stream; `tlast` is ignored.
- `axis_i_tdata`: in, 8. Response stream byte.
- `axis_i_tready`: out, 1. Response stream handshake.

## Operation
- **Accept:** a request is accepted when `s_wb_cyc & s_wb_stb & !s_wb_stall`. On acceptance, latch `we`, `sel`, `addr` (zero-extended to `ADDR_BYTES*8` bits) and `dat_m2s`.
- **Request frame:** bytes are sent in this order:
  - Command byte: `{sel zero-extended to 4 bits, 3'b000, we}`.
  - `ADDR_BYTES` address bytes, MSB first.
  - If `we`, `BYTES` data bytes, MSB first.
  - `axis_o_tlast` is asserted on the final byte of the frame.
- **Response frame:**
  - Write: exactly 1 byte, value ignored.
  - Read: exactly `BYTES` bytes, MSB first, shifted into `s_wb_dat_s2m`.
- **States:**
  - IDLE → TX_CMD on accept.
  - TX_CMD → TX_ADDR.
  - TX_ADDR → TX_DATA if `we`, else RX_RESP, after `ADDR_BYTES` beats.
  - TX_DATA → RX_RESP after `BYTES` beats.
  - RX_RESP → ACK after the expected response beat count.
  - ACK → IDLE.
  - Every TX_* transition advances only on an `axis_o_tvalid & axis_o_tready` beat.
- **Byte counter:** a single counter, width `clog2(max(ADDR_BYTES,BYTES))+1`, cleared on every state change.
- **Output signals:**
  - `s_wb_stall = (state != IDLE)`.
  - `axis_o_tvalid = 1` in TX_* states.
  - `axis_i_tready = 1` only in RX_RESP.
- **Abort:** if `s_wb_cyc` falls after acceptance, set an abort flag. The frame is still sent and the response still consumed, but `s_wb_ack` is suppressed, so the link stays in frame sync. The flag clears in IDLE.
- **Read data:** `s_wb_dat_s2m` is updated only by read response beats and holds its value until the next read. A write leaves it unchanged.
- **Reset:** asynchronous. It returns the FSM to IDLE mid-frame and drops any partial frame (the far end must also be resynchronised). All outputs go to 0: `s_wb_ack`, `s_wb_stall`, `s_wb_dat_s2m`, `axis_o_tvalid`, `axis_o_tlast`, `axis_o_tdata`, `axis_i_tready`.

## Timing
- **Accept to request stream:** acceptance is on edge N. The command byte is registered and `axis_o_tvalid` is high from cycle N+1. `s_wb_stall` is high from N+1 through the ACK cycle inclusive.
- **Beat rate:** one beat per cycle when `axis_o_tready` is held high. Write frame: `1+ADDR_BYTES+BYTES` cycles minimum; read frame: `1+ADDR_BYTES` cycles.
- **Stable output while stalled:** while `axis_o_tvalid & !axis_o_tready`, `axis_o_tdata` and `axis_o_tlast` hold stable. No byte may be dropped or duplicated.
- **Response to ack:** the last response beat is on edge M. `s_wb_ack` is high for exactly cycle M+1, with `s_wb_dat_s2m` valid in that cycle. The FSM is in IDLE at M+2.
- **Back-to-back requests:** a new request can be accepted at M+2 at the earliest.
- **Overlap:** a response beat presented while in TX_* is not consumed (`axis_i_tready = 0`).

## Test plan
- **Write, ADDR_BITS=8, BYTES=1:** write addr 0x5A, data 0xC3, sel 1, `axis_o_tready` held 1.
  - Requires bytes 0x11, 0x5A, 0xC3, with `tlast` only on 0xC3.
  - Feed response 0x00; requires `s_wb_ack` for exactly one cycle, at M+1.
- **Read, ADDR_BITS=8, BYTES=1:** read addr 0x07.
  - Requires bytes 0x10, 0x07, with `tlast` on 0x07.
  - Feed 0xA5; requires ack with `s_wb_dat_s2m` = 0xA5.
- **Read, ADDR_BITS=12, BYTES=2:** read addr 0xABC, sel 3.
  - Requires bytes 0x30, 0x0A, 0xBC.
  - Feed 0x12 then 0x34; requires `s_wb_dat_s2m` = 0x1234.
- **Backpressure:** random `axis_o_tready`/`axis_i_tvalid` over 1000 random write/read pairs.
  - Frame bytes must match a reference model exactly, with tdata stable while stalled.
  - Read data must equal the last written value per address (responder model is a 256-byte RAM).
- **Busy and abort:**
  - A second `stb` during a busy transaction is held off by `s_wb_stall` and accepted only after the ack.
  - Drop `s_wb_cyc` during TX_ADDR; requires the full frame to be sent, the response consumed, and no `s_wb_ack`.
- **Reset mid-frame:** assert `sresetn=0` asynchronously during TX_DATA.
  - All outputs must be 0 immediately.
  - After release, a fresh read frame must start with the command byte.

Source files
------------

// File: rtl/wb_serial_bridge.sv
// wb_serial_bridge
//   Pipelined Wishbone slave that forwards each accepted bus cycle as a
//   byte-serial request frame on an AXI-Stream output and completes the
//   cycle when the byte-serial response arrives on an AXI-Stream input.
//   One transaction outstanding at a time.
//
// Ports
//   clk, sresetn            : clock, asynchronous active-low reset
//   s_wb_*                  : Wishbone slave (cyc/stb/we/addr/sel/dat in,
//                             dat_s2m/ack/stall out)
//   axis_o_*                : request byte stream out (tdata/tvalid/tlast, tready in)
//   axis_i_*                : response byte stream in (tdata/tvalid/tlast, tready out)
//
// Request frame : {sel,3'b000,we}, address bytes MSB first, write data MSB first.
// Response frame: 1 byte for a write (ignored), BYTES bytes MSB first for a read.
module wb_serial_bridge #(
    parameter int ADDR_BITS = 8,
    parameter int BYTES     = 1
) (
    input  logic                   clk,
    input  logic                   sresetn,
    input  logic                   s_wb_cyc,
    input  logic                   s_wb_stb,
    input  logic                   s_wb_we,
    input  logic [ADDR_BITS-1:0]   s_wb_addr,
    input  logic [BYTES-1:0]       s_wb_sel,
    input  logic [8*BYTES-1:0]     s_wb_dat_m2s,
    output logic [8*BYTES-1:0]     s_wb_dat_s2m,
    output logic                   s_wb_ack,
    output logic                   s_wb_stall,
    input  logic                   axis_o_tready,
    output logic                   axis_o_tvalid,
    output logic                   axis_o_tlast,
    output logic [7:0]             axis_o_tdata,
    input  logic                   axis_i_tvalid,
    input  logic                   axis_i_tlast,
    input  logic [7:0]             axis_i_tdata,
    output logic                   axis_i_tready
);

    localparam int ADDR_BYTES = (ADDR_BITS + 7) / 8;
    localparam int AW         = ADDR_BYTES * 8;
    localparam int DW         = BYTES * 8;
    localparam int MAXB       = (ADDR_BYTES > BYTES) ? ADDR_BYTES : BYTES;
    localparam int CW         = $clog2(MAXB) + 1;

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_ADDR,
        TX_DATA,
        RX_RESP,
        ACK
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic            abort;
    logic [AW-1:0]   addr_sr;
    logic [DW-1:0]   data_sr;
    logic [DW+7:0]   rx_shift;
    logic            resp_last;

    // Response framing does not depend on the stream's own tlast.
    logic unused_tlast;
    assign unused_tlast = axis_i_tlast;

    always_comb begin
        rx_shift  = {s_wb_dat_s2m, axis_i_tdata};
        resp_last = we_q ? (cnt == '0) : (int'(cnt) == BYTES - 1);
    end

    // Address and data are shifted out of their latches MSB first; the byte
    // on axis_o_tdata is always registered one beat ahead of the handshake.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            abort         <= 1'b0;
            addr_sr       <= '0;
            data_sr       <= '0;
            s_wb_dat_s2m  <= '0;
            s_wb_ack      <= 1'b0;
            s_wb_stall    <= 1'b0;
            axis_o_tvalid <= 1'b0;
            axis_o_tlast  <= 1'b0;
            axis_o_tdata  <= '0;
            axis_i_tready <= 1'b0;
        end else begin
            if (state != IDLE && !s_wb_cyc)
                abort <= 1'b1;

            case (state)
                IDLE: begin
                    abort <= 1'b0;
                    if (s_wb_cyc && s_wb_stb) begin
                        we_q          <= s_wb_we;
                        addr_sr       <= AW'(s_wb_addr);
                        data_sr       <= s_wb_dat_m2s;
                        axis_o_tdata  <= {4'(s_wb_sel), 3'b000, s_wb_we};
                        axis_o_tvalid <= 1'b1;
                        axis_o_tlast  <= 1'b0;
                        s_wb_stall    <= 1'b1;
                        cnt           <= '0;
                        state         <= TX_CMD;
                    end
                end

                TX_CMD: begin
                    if (axis_o_tready) begin
                        axis_o_tdata <= addr_sr[AW-1 -: 8];
                        addr_sr      <= addr_sr << 8;
                        axis_o_tlast <= (ADDR_BYTES == 1) && !we_q;
                        cnt          <= '0;
                        state        <= TX_ADDR;
                    end
                end

                TX_ADDR: begin
                    if (axis_o_tready) begin
                        if (int'(cnt) == ADDR_BYTES - 1) begin
                            cnt <= '0;
                            if (we_q) begin
                                axis_o_tdata <= data_sr[DW-1 -: 8];
                                data_sr      <= data_sr << 8;
                                axis_o_tlast <= (BYTES == 1);
                                state        <= TX_DATA;
                            end else begin
                                axis_o_tvalid <= 1'b0;
                                axis_o_tlast  <= 1'b0;
                                axis_o_tdata  <= '0;
                                axis_i_tready <= 1'b1;
                                state         <= RX_RESP;
                            end
                        end else begin
                            axis_o_tdata <= addr_sr[AW-1 -: 8];
                            addr_sr      <= addr_sr << 8;
                            axis_o_tlast <= !we_q && (int'(cnt) + 2 == ADDR_BYTES);
                            cnt          <= cnt + CW'(1);
                        end
                    end
                end

                TX_DATA: begin
                    if (axis_o_tready) begin
                        if (int'(cnt) == BYTES - 1) begin
                            cnt           <= '0;
                            axis_o_tvalid <= 1'b0;
                            axis_o_tlast  <= 1'b0;
                            axis_o_tdata  <= '0;
                            axis_i_tready <= 1'b1;
                            state         <= RX_RESP;
                        end else begin
                            axis_o_tdata <= data_sr[DW-1 -: 8];
                            data_sr      <= data_sr << 8;
                            axis_o_tlast <= (int'(cnt) + 2 == BYTES);
                            cnt          <= cnt + CW'(1);
                        end
                    end
                end

                RX_RESP: begin
                    if (axis_i_tvalid) begin
                        if (!we_q)
                            s_wb_dat_s2m <= rx_shift[DW-1:0];
                        if (resp_last) begin
                            cnt           <= '0;
                            axis_i_tready <= 1'b0;
                            // An abandoned cycle still drains its response but never acks.
                            s_wb_ack      <= !(abort || !s_wb_cyc);
                            state         <= ACK;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                ACK: begin
                    s_wb_ack   <= 1'b0;
                    s_wb_stall <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
